mtm_alu_deserializer: RTL and testbench
=======================================

Name: mtm_alu_deserializer

Overview:
Serial input stage of the mtm_Alu. It sits directly upstream of the ALU core and receives 11-bit frames on sin, one bit per clock. It assembles 8 DATA frames plus 1 CMD frame into operands B, A and an opcode, and checks frame count, CRC4 and opcode validity. It then presents either a one-cycle operand strobe or a one-cycle error strobe to the core and the output serializer.

Parameters:
None. The format is fixed: 8 DATA frames, 1 CMD frame, 32-bit operands.

Ports:
clk  in  1  system clock; sin sampled on rising edge
rst  in  1  asynchronous, active-high reset
sin  in  1  serial input, synchronous to clk, idles high
out_valid  out  1  one-cycle strobe: a_out/b_out/op_out valid
a_out  out  32  operand A (second four DATA bytes, MSB byte first)
b_out  out  32  operand B (first four DATA bytes, MSB byte first)
op_out  out  3  opcode from CMD frame
err_valid  out  1  one-cycle strobe: err_flags valid
err_flags  out  3  {ERR_DATA, ERR_CRC, ERR_OP}, one-hot

Behaviour:
- Reset (any time, asynchronous): all outputs 0; FSM to IDLE; frame counter 0; CRC register 0. A partially received packet is discarded.
- Frame format, MSB first: start(0), type (0 = DATA, 1 = CMD), 8 payload bits, stop(1). CMD payload is {0, OP[2:0], CRC[3:0]}.
- Frame FSM (sub-module), one sin sample per clock:
  - IDLE: sin==0 goes to TYPE; otherwise stay.
  - TYPE: latch the type bit, go to PAYLOAD.
  - PAYLOAD: shift 8 bits (counter 7..0), go to STOP.
  - STOP: sin==1 raises frame_done with type and byte for one cycle; sin==0 raises frame_err. Both return to IDLE. The next start bit may arrive in the cycle immediately after STOP (back-to-back frames).
- Packet sequencer:
  - DATA frame_done: shift byte into a 64-bit {B,A} register; data_cnt++.
  - 9th DATA frame (data_cnt==8 when a DATA frame_done arrives): err ERR_DATA; reset packet state.
  - CMD frame_done with data_cnt!=8: err ERR_DATA.
  - CMD frame_done with data_cnt==8: compare CRC, then check opcode.
  - frame_err (stop bit 0): err ERR_DATA; reset packet state.
  - After any result (valid or error): data_cnt=0, CRC register cleared.
- CRC4:
  - Polynomial x^4+x+1, init 0000, no reflection, no final XOR.
  - Covers the 68-bit string {B[31:0], A[31:0], 1'b1, OP[2:0]}, MSB first.
  - Computed serially as bits arrive: the 64 DATA payload bits, then a constant 1 at the CMD type bit, then the 3 OP bits. The leading CMD payload 0 and the CRC bits are not fed.
- Result checks and priority:
  - Priority: ERR_DATA > ERR_CRC > ERR_OP. Exactly one flag is set per err_valid.
  - CRC mismatch gives ERR_CRC (100 -> 010 encoding: err_flags=3'b010).
  - OP not in {000 AND, 001 OR, 100 ADD, 101 SUB} gives ERR_OP (err_flags=3'b001).
  - ERR_DATA gives err_flags=3'b100.
  - Otherwise out_valid=1 with a_out, b_out, op_out.
- Output timing:
  - out_valid/err_valid are registered and rise in the cycle after the stop-bit sample of the terminating frame. They last exactly 1 cycle.
  - out_valid and err_valid are never high together.
  - a_out, b_out, op_out and err_flags hold their values until the next strobe.
- A new packet may start in the cycle after a strobe. No backpressure: downstream must accept every strobe.

Decomposition:
- Shared package mtm_alu_pkg holds:
  - opcode constants AND/OR/ADD/SUB;
  - frame type constants TYPE_DATA/TYPE_CMD;
  - error bit indices ERR_DATA=2, ERR_CRC=1, ERR_OP=0;
  - the CRC4 polynomial constant.
- One sub-module, mtm_alu_frame_rx: the start/type/payload/stop FSM, producing frame_done, frame_err, type and byte. The sequencer and CRC stay in the top module.

Test Plan:
- Valid ADD, A=0x11111111, B=0x22222222, correct CRC -> one out_valid; a_out=0x11111111, b_out=0x22222222, op_out=3'b100; err_valid never high.
- Same operands, ADD, CRC=4'b0000 -> err_valid with err_flags=3'b010; no out_valid.
- Same operands, OP=3'b010, correct CRC -> err_valid with err_flags=3'b001.
- 7 DATA frames then a correct CMD frame -> err_flags=3'b100, one cycle after the CMD stop bit.
- 9 DATA frames with no CMD -> err_flags=3'b100, one cycle after the 9th stop bit. A following valid packet (SUB, A=B=0xFFFFFFFF) -> out_valid with op_out=3'b101.
- rst pulsed mid-way through the 5th DATA frame, then a full valid OR packet with A=0, B=0xFFFFFFFF -> outputs 0 during reset, then exactly one out_valid with the correct operands.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// Shared constants, frame receiver states and CRC4 helpers for the mtm_Alu
// serial input stage.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CMD  = 1'b1;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam int DATA_FRAMES = 8;

  // x^4 + x + 1, the x^4 term is implicit in the shift.
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_TYPE,
    RX_PAYLOAD,
    RX_STOP
  } rx_state_e;

  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[3];
    return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Receives one 11-bit frame (start, type, 8 payload bits, stop) per pass and
// flags completion or a bad stop bit during the stop-bit sample cycle.
module mtm_alu_frame_rx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       frame_done,
  output logic       frame_err,
  output logic       frame_type,
  output logic [7:0] frame_byte,
  output logic [2:0] bit_cnt,
  output rx_state_e  rx_state
);

  rx_state_e state, state_next;

  assign rx_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      frame_type <= TYPE_DATA;
      frame_byte <= 8'h00;
      bit_cnt    <= 3'd0;
    end else begin
      state <= state_next;
      if (state == RX_TYPE) begin
        frame_type <= sin;
        bit_cnt    <= 3'd7;
      end
      if (state == RX_PAYLOAD) begin
        frame_byte <= {frame_byte[6:0], sin};
        bit_cnt    <= bit_cnt - 3'd1;
      end
    end
  end

  // frame_done / frame_err are combinational in RX_STOP so the consumer can
  // register its result on the stop-bit sample edge itself.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      RX_IDLE:    if (!sin) state_next = RX_TYPE;
      RX_TYPE:    state_next = RX_PAYLOAD;
      RX_PAYLOAD: if (bit_cnt == 3'd0) state_next = RX_STOP;
      RX_STOP: begin
        frame_done = sin;
        frame_err  = !sin;
        state_next = RX_IDLE;
      end
      default:    state_next = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Packet sequencer: collects 8 DATA frames and one CMD frame into B, A and an
// opcode, runs CRC4 on the fly and emits one operand or error strobe.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [2:0]  op_out,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  logic       frame_done;
  logic       frame_err;
  logic       frame_type;
  logic [7:0] frame_byte;
  logic [2:0] bit_cnt;
  rx_state_e  rx_state;

  mtm_alu_frame_rx u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_type (frame_type),
    .frame_byte (frame_byte),
    .bit_cnt    (bit_cnt),
    .rx_state   (rx_state)
  );

  logic [63:0] data_sr;
  logic [3:0]  data_cnt;
  logic [3:0]  crc;

  logic       feed_en;
  logic       shift_en;
  logic       res_valid;
  logic       res_err;
  logic [2:0] res_flags;

  // CRC input bits: all DATA payload bits, the CMD type bit (always 1) and
  // the three OP bits at payload positions 6..4. The CRC field is not fed.
  always_comb begin
    feed_en = 1'b0;
    if (rx_state == RX_TYPE && sin == TYPE_CMD) begin
      feed_en = 1'b1;
    end else if (rx_state == RX_PAYLOAD) begin
      if (frame_type == TYPE_DATA) begin
        feed_en = 1'b1;
      end else if (bit_cnt == 3'd6 || bit_cnt == 3'd5 || bit_cnt == 3'd4) begin
        feed_en = 1'b1;
      end
    end
  end

  // Result decision in the stop-bit cycle; earlier branches take priority.
  always_comb begin
    shift_en  = 1'b0;
    res_valid = 1'b0;
    res_err   = 1'b0;
    res_flags = 3'b000;
    if (frame_err) begin
      res_err             = 1'b1;
      res_flags[ERR_DATA] = 1'b1;
    end else if (frame_done) begin
      if (frame_type == TYPE_DATA) begin
        if (data_cnt == 4'(DATA_FRAMES)) begin
          res_err             = 1'b1;
          res_flags[ERR_DATA] = 1'b1;
        end else begin
          shift_en = 1'b1;
        end
      end else if (data_cnt != 4'(DATA_FRAMES)) begin
        res_err             = 1'b1;
        res_flags[ERR_DATA] = 1'b1;
      end else if (crc != frame_byte[3:0]) begin
        res_err            = 1'b1;
        res_flags[ERR_CRC] = 1'b1;
      end else if (!op_is_valid(frame_byte[6:4])) begin
        res_err           = 1'b1;
        res_flags[ERR_OP] = 1'b1;
      end else begin
        res_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sr   <= 64'd0;
      data_cnt  <= 4'd0;
      crc       <= 4'd0;
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      a_out     <= 32'd0;
      b_out     <= 32'd0;
      op_out    <= 3'd0;
      err_flags <= 3'd0;
    end else begin
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      if (res_valid || res_err) begin
        data_cnt <= 4'd0;
        crc      <= 4'd0;
        if (res_valid) begin
          out_valid <= 1'b1;
          b_out     <= data_sr[63:32];
          a_out     <= data_sr[31:0];
          op_out    <= frame_byte[6:4];
        end else begin
          err_valid <= 1'b1;
          err_flags <= res_flags;
        end
      end else begin
        if (shift_en) begin
          data_sr  <= {data_sr[55:0], frame_byte};
          data_cnt <= data_cnt + 4'd1;
        end
        if (feed_en) begin
          crc <= crc4_step(crc, sin);
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed and randomized checks of mtm_alu_deserializer against a packet-level
// reference model (CRC by polynomial long division).
module tb_mtm_alu_deserializer;
  import mtm_alu_pkg::*;

  localparam int W = 71;  // {is_err, flags[2:0], op[2:0], a[31:0], b[31:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic sin;
  always #5 clk = ~clk;

  logic        out_valid;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [2:0]  op_out;
  logic        err_valid;
  logic [2:0]  err_flags;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_valid (out_valid),
    .a_out     (a_out),
    .b_out     (b_out),
    .op_out    (op_out),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stop_cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_cyc_q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: capture every strobe with its cycle number
  always @(posedge clk) begin
    #1;
    cyc++;
    if (out_valid) begin
      obs_q.push_back({1'b0, 3'b000, op_out, a_out, b_out});
      obs_cyc_q.push_back(cyc);
    end
    if (err_valid) begin
      obs_q.push_back({1'b1, err_flags, 67'd0});
      obs_cyc_q.push_back(cyc);
    end
    if (out_valid || err_valid) begin
      checks++;
      assert (!(out_valid && err_valid)) else begin
        failures++;
        $error("FAIL both_strobes observed=%b%b expected=one", out_valid, err_valid);
      end
    end
  end

  // reference model
  function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    end
    return m[3:0];
  endfunction

  function automatic logic [W-1:0] ref_result(input int ndata, input logic [31:0] a,
                                              input logic [31:0] b, input logic [2:0] op,
                                              input logic [3:0] crc_sent);
    if (ndata != 8) return {1'b1, 3'b100, 67'd0};
    if (crc_sent != ref_crc(a, b, op)) return {1'b1, 3'b010, 67'd0};
    if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) return {1'b1, 3'b001, 67'd0};
    return {1'b0, 3'b000, op, a, b};
  endfunction

  // driver tasks
  task automatic send_frame(input logic typ, input logic [7:0] data);
    logic [10:0] bits;
    bits = {1'b0, typ, data, 1'b1};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = bits[i];
    end
    @(posedge clk);
    #2;
    stop_cyc = cyc;
  endtask

  task automatic send_data(input int n, input logic [63:0] data);
    for (int k = 0; k < n; k++) send_frame(TYPE_DATA, data[63 - 8 * (k % 8) -: 8]);
  endtask

  task automatic send_packet(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [3:0] crc);
    send_data(8, {b, a});
    send_frame(TYPE_CMD, {1'b0, op, crc});
  endtask

  // scoreboard: exactly the expected strobes, in the cycle after the last stop bit
  task automatic check_result(input string tag, input logic [W-1:0] exp);
    int exp_cyc;
    exp_cyc = stop_cyc;
    exp_q.push_back(exp);
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, W'(obs_q.size()), W'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      chk(tag, obs_q.pop_front(), exp_q.pop_front());
      chk({tag, "_cycle"}, W'(obs_cyc_q.pop_front()), W'(exp_cyc));
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_out_valid"}, W'(out_valid), '0);
    chk({tag, "_err_valid"}, W'(err_valid), '0);
    chk({tag, "_a_out"}, W'(a_out), '0);
    chk({tag, "_b_out"}, W'(b_out), '0);
    chk({tag, "_op_out"}, W'(op_out), '0);
    chk({tag, "_err_flags"}, W'(err_flags), '0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  crc;
    logic [10:0] bits;

    rst = 1'b1;
    sin = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // valid ADD
    a = 32'h11111111; b = 32'h22222222;
    send_packet(a, b, OP_ADD, ref_crc(a, b, OP_ADD));
    check_result("add_ok", {1'b0, 3'b000, 3'b100, 32'h11111111, 32'h22222222});

    // bad CRC; operand outputs must hold from the previous strobe
    send_packet(a, b, OP_ADD, 4'b0000);
    check_result("crc_bad", ref_result(8, a, b, OP_ADD, 4'b0000));
    chk("hold_a", W'(a_out), W'(32'h11111111));
    chk("hold_b", W'(b_out), W'(32'h22222222));
    chk("hold_op", W'(op_out), W'(3'b100));

    // invalid opcode
    send_packet(a, b, 3'b010, ref_crc(a, b, 3'b010));
    check_result("op_bad", {1'b1, 3'b001, 67'd0});

    // 7 DATA then CMD
    send_data(7, {b, a});
    send_frame(TYPE_CMD, {1'b0, OP_ADD, ref_crc(a, b, OP_ADD)});
    check_result("short", {1'b1, 3'b100, 67'd0});

    // 9 DATA, then a valid SUB packet
    send_data(9, {b, a});
    check_result("nine_data", {1'b1, 3'b100, 67'd0});
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    send_packet(a, b, OP_SUB, ref_crc(a, b, OP_SUB));
    check_result("sub_ok", ref_result(8, a, b, OP_SUB, ref_crc(a, b, OP_SUB)));

    // reset mid 5th DATA frame
    send_data(4, 64'hDEADBEEF_01234567);
    bits = {1'b0, TYPE_DATA, 8'hA5, 1'b1};
    for (int i = 10; i >= 6; i--) begin
      @(negedge clk);
      sin = bits[i];
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    sin = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("held_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    obs_cyc_q.delete();
    a = 32'h00000000; b = 32'hFFFFFFFF;
    send_packet(a, b, OP_OR, ref_crc(a, b, OP_OR));
    check_result("or_after_reset", {1'b0, 3'b000, 3'b001, 32'h00000000, 32'hFFFFFFFF});

    // randomized packets
    for (int n = 0; n < 20; n++) begin
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      crc = ($urandom_range(0, 3) != 0) ? ref_crc(a, b, op) : 4'($urandom_range(0, 15));
      send_packet(a, b, op, crc);
      check_result("rand", ref_result(8, a, b, op, crc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
